// File: rtl/unique_draw_pkg.sv
// Shared types and defaults for the unique draw sequencer.
package unique_draw_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    PROBE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [7:0] DEFAULT_SEED = 8'hA5;
  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

  // Number of distinct values for a given value width.
  function automatic int unsigned pool_size(input int unsigned num_w);
    return 32'd1 << num_w;
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shift Galois LFSR; reloads SEED on reset.
module lfsr_galois
  import unique_draw_pkg::*;
#(
  parameter int unsigned         LFSR_W = 8,
  parameter logic [LFSR_W-1:0]   SEED   = LFSR_W'(DEFAULT_SEED),
  parameter logic [LFSR_W-1:0]   TAPS   = LFSR_W'(DEFAULT_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // One Galois step: shift right, fold taps in when the outgoing bit is 1.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ TAPS;
    end
  end

  // LFSR register, stepping every cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/unique_draw_sequencer.sv
// Draws every value of a 2^NUM_W pool once, in LFSR order with upward probing.
module unique_draw_sequencer
  import unique_draw_pkg::*;
#(
  parameter int unsigned       NUM_W  = 3,
  parameter int unsigned       LFSR_W = 8,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
  parameter int unsigned       PERIOD = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_restart,
  output logic [NUM_W-1:0] num,
  output logic             num_valid,
  output logic [NUM_W:0]   draw_cnt,
  output logic             busy,
  output logic             all_done
);

  localparam int unsigned       POOL     = pool_size(NUM_W);
  localparam int unsigned       TMR_W    = $clog2(PERIOD) + 1;
  localparam int unsigned       CNT_W    = NUM_W + 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(POOL);

  state_e            state_q, state_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic              num_valid_q, num_valid_d;
  logic [CNT_W-1:0]  draw_cnt_q, draw_cnt_d;
  logic [POOL-1:0]   used_q, used_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [NUM_W-1:0]  probe_q, probe_d;
  logic              busy_q, busy_d;
  logic              all_done_q, all_done_d;

  logic [LFSR_W-1:0] lfsr_value;
  logic [NUM_W-1:0]  cand_c;
  logic              cand_free_c;
  logic              probe_free_c;
  logic              timer_done_c;
  logic              restart_c;
  logic              accept_c;
  logic [NUM_W-1:0]  accept_val_c;
  logic              unused_lfsr_bits;

  lfsr_galois #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED),
    .TAPS   (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr_value)
  );

  assign cand_c           = lfsr_value[NUM_W-1:0];
  assign unused_lfsr_bits = ^lfsr_value;
  assign cand_free_c      = ~used_q[cand_c];
  assign probe_free_c     = ~used_q[probe_q];
  assign timer_done_c     = ~pause & (timer_q == TMR_LAST);
  assign restart_c        = auto_restart | start;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRAW;
      DRAW:    state_d = cand_free_c ? WAIT : PROBE;
      PROBE:   if (probe_free_c) state_d = WAIT;
      WAIT:    if (timer_done_c) state_d = (draw_cnt_q == CNT_FULL) ? DONE : DRAW;
      DONE:    if (restart_c) state_d = DRAW;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; an accept loads num, mask, count and timer together.
  always_comb begin
    num_d        = num_q;
    num_valid_d  = 1'b0;
    draw_cnt_d   = draw_cnt_q;
    used_d       = used_q;
    timer_d      = timer_q;
    probe_d      = probe_q;
    accept_c     = 1'b0;
    accept_val_c = cand_c;
    unique case (state_q)
      DRAW: begin
        if (cand_free_c) begin
          accept_c = 1'b1;
        end else begin
          probe_d = cand_c + NUM_W'(1);
        end
      end
      PROBE: begin
        if (probe_free_c) begin
          accept_c     = 1'b1;
          accept_val_c = probe_q;
        end else begin
          probe_d = probe_q + NUM_W'(1);
        end
      end
      WAIT: begin
        if (!pause && !timer_done_c) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DONE: begin
        if (restart_c) begin
          used_d     = '0;
          draw_cnt_d = '0;
        end
      end
      default: ;
    endcase
    if (accept_c) begin
      num_d                = accept_val_c;
      num_valid_d          = 1'b1;
      used_d[accept_val_c] = 1'b1;
      draw_cnt_d           = draw_cnt_q + CNT_W'(1);
      timer_d              = '0;
    end
    busy_d     = (state_d == DRAW) || (state_d == PROBE) || (state_d == WAIT);
    all_done_d = (state_d == DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q       <= '0;
      num_valid_q <= 1'b0;
      draw_cnt_q  <= '0;
      used_q      <= '0;
      timer_q     <= '0;
      probe_q     <= '0;
      busy_q      <= 1'b0;
      all_done_q  <= 1'b0;
    end else begin
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
      draw_cnt_q  <= draw_cnt_d;
      used_q      <= used_d;
      timer_q     <= timer_d;
      probe_q     <= probe_d;
      busy_q      <= busy_d;
      all_done_q  <= all_done_d;
    end
  end

  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign draw_cnt  = draw_cnt_q;
  assign busy      = busy_q;
  assign all_done  = all_done_q;

endmodule

// File: tb/tb_unique_draw_sequencer.sv
// Bench for unique_draw_sequencer: cycle-level reference model with a pulse scoreboard.
module tb_unique_draw_sequencer;

  localparam int unsigned PER_A = 4;
  localparam int unsigned PER_B = 2;
  localparam logic [7:0]  SEED  = 8'hA5;
  localparam logic [7:0]  TAPS  = 8'hB8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, pause_a = 1'b0, auto_a = 1'b0;
  logic start_b = 1'b0, pause_b = 1'b0, auto_b = 1'b0;
  logic [2:0] num_a;
  logic       nv_a, busy_a, done_a;
  logic [3:0] cnt_a;
  logic [0:0] num_b;
  logic       nv_b, busy_b, done_b;
  logic [1:0] cnt_b;

  unique_draw_sequencer #(
    .NUM_W(3), .LFSR_W(8), .SEED(SEED), .TAPS(TAPS), .PERIOD(PER_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pause(pause_a), .auto_restart(auto_a),
    .num(num_a), .num_valid(nv_a), .draw_cnt(cnt_a), .busy(busy_a), .all_done(done_a)
  );

  unique_draw_sequencer #(
    .NUM_W(1), .LFSR_W(8), .SEED(SEED), .TAPS(TAPS), .PERIOD(PER_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pause(pause_b), .auto_restart(auto_b),
    .num(num_b), .num_valid(nv_b), .draw_cnt(cnt_b), .busy(busy_b), .all_done(done_b)
  );

  always #5 clk = ~clk;

  // Reference LFSR: right-shift Galois, x^8+x^6+x^5+x^4+1.
  logic [7:0] lm;
  always @(posedge clk) begin
    if (!rst_n) lm <= SEED;
    else        lm <= {1'b0, lm[7:1]} ^ (lm[0] ? TAPS : 8'h00);
  end

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  typedef enum int {M_IDLE, M_DRAW, M_WAIT, M_DONE} mph_e;
  typedef struct { int v; int cyc; } exp_t;
  typedef struct { bit au; int n; int pause_at; int pause_len; bit busy_start; } rec_t;

  mph_e       ph = M_IDLE;
  bit         draw_first;
  int         acc_cyc, left, pend_v;
  logic [7:0] used = 8'h00;
  int         e_num = 0, e_cnt = 0;
  exp_t       sb[$];
  int         got_v[$], got_c[$], gb_v[$], gb_c[$];
  rec_t       tbl[4];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_ge(input string nm, input int act, input int lo);
    n_vec++;
    if (act < lo) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %0d, expected >= %0d", nm, cyc, act, lo);
    end
  endtask

  // One clock cycle: compare outputs, drive this cycle's inputs, advance the model.
  task automatic tick(input bit st, input bit pz, input bit au, input bit rn, input bit stb);
    logic [2:0] v;
    int         p;
    bit         ev;
    @(negedge clk);
    cyc++;
    ev = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("num_valid", int'(nv_a), int'(ev));
    if (ev && nv_a) chk("pulse_value", int'(num_a), sb[0].v);
    chk("num", int'(num_a), e_num);
    chk("draw_cnt", int'(cnt_a), e_cnt);
    chk("busy", int'(busy_a), int'(ph == M_DRAW || ph == M_WAIT));
    chk("all_done", int'(done_a), int'(ph == M_DONE));
    while (sb.size() > 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
    if (nv_a) begin got_v.push_back(int'(num_a)); got_c.push_back(cyc); end
    if (nv_b) begin gb_v.push_back(int'(num_b)); gb_c.push_back(cyc); end

    start_a = st; pause_a = pz; auto_a = au; rst_n = rn; start_b = stb;

    if (!rn) begin
      ph = M_IDLE; e_num = 0; e_cnt = 0; used = 8'h00; sb.delete();
    end else begin
      case (ph)
        M_IDLE: if (st) begin ph = M_DRAW; draw_first = 1'b1; end
        M_DRAW: begin
          if (draw_first) begin
            v = lm[2:0];
            p = 0;
            while (used[v]) begin v = v + 3'd1; p++; end
            used[v]    = 1'b1;
            pend_v     = int'(v);
            acc_cyc    = cyc + p;
            draw_first = 1'b0;
            sb.push_back('{pend_v, cyc + 1 + p});
          end
          if (cyc == acc_cyc) begin
            ph = M_WAIT; left = PER_A; e_num = pend_v; e_cnt = e_cnt + 1;
          end
        end
        M_WAIT: if (!pz) begin
          left--;
          if (left == 0) begin
            if (e_cnt == 8) ph = M_DONE;
            else begin ph = M_DRAW; draw_first = 1'b1; end
          end
        end
        M_DONE: if (au || st) begin
          used = 8'h00; e_cnt = 0; ph = M_DRAW; draw_first = 1'b1;
        end
        default: ph = M_IDLE;
      endcase
    end
  endtask

  // Runs one table record from IDLE or DONE and checks the sequence-level properties.
  task automatic run_rec(input rec_t r);
    int budget, pq, nc, ming, mask;
    bit pz, au, st;
    got_v.delete(); got_c.delete();
    tick(1'b1, 1'b0, r.au, 1'b1, 1'b0);
    budget = 0;
    pq = -1;
    while (!(got_v.size() >= r.n && ph == M_DONE) && budget < 3000) begin
      if (r.pause_at > 0 && pq < 0 && got_c.size() >= r.pause_at) pq = got_c[r.pause_at-1];
      nc = cyc + 1;
      pz = (pq >= 0) && (nc >= pq + 1) && (nc <= pq + r.pause_len);
      au = r.au && (got_v.size() < r.n);
      st = r.busy_start && (got_c.size() > 0) && (nc == got_c[0] + 2);
      tick(st, pz, au, 1'b1, 1'b0);
      budget++;
    end
    chk("seq_within_budget", int'(budget < 3000), 1);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pulse_count", got_v.size(), r.n);
    for (int g = 0; g < got_v.size() / 8; g++) begin
      mask = 0;
      for (int i = 0; i < 8; i++) mask = mask | (1 << got_v[g*8 + i]);
      chk("permutation_mask", mask, 255);
    end
    if (got_c.size() > 1) begin
      ming = 1000000;
      for (int i = 1; i < got_c.size(); i++)
        if (got_c[i] - got_c[i-1] < ming) ming = got_c[i] - got_c[i-1];
      chk_ge("min_pulse_gap", ming, PER_A + 1);
    end
    if (r.pause_at > 0 && got_c.size() > r.pause_at)
      chk_ge("paused_gap", got_c[r.pause_at] - got_c[r.pause_at-1], PER_A + 1 + r.pause_len);
    chk("end_all_done", int'(done_a), 1);
    chk("end_draw_cnt", int'(cnt_a), 8);
    chk("end_busy", int'(busy_a), 0);
  endtask

  initial begin : main
    int budget, mask;
    tbl[0] = '{1'b0,  8, 0,  0, 1'b0};  // plain one-shot sequence
    tbl[1] = '{1'b0,  8, 3, 10, 1'b0};  // 10-cycle pause after third value
    tbl[2] = '{1'b1, 16, 0,  0, 1'b1};  // auto restart, start while busy
    tbl[3] = '{1'b0,  8, 5,  3, 1'b1};  // restart from DONE, short pause

    // Reset held three cycles, then idle without start.
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b_reset_cnt", int'(cnt_b), 0);
    chk("b_reset_busy", int'(busy_b), 0);
    chk("b_reset_valid", int'(nv_b), 0);

    for (int k = 0; k < 4; k++) run_rec(tbl[k]);

    // Reset after three draws discards progress.
    got_v.delete(); got_c.delete();
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    budget = 0;
    while (got_v.size() < 3 && budget < 500) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      budget++;
    end
    chk("three_draws_budget", int'(budget < 500), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mid_reset_num", int'(num_a), 0);
    chk("mid_reset_cnt", int'(cnt_a), 0);
    chk("mid_reset_busy", int'(busy_a), 0);
    chk("mid_reset_done", int'(done_a), 0);
    run_rec(tbl[0]);

    // Single-bit pool yields exactly {0,1}.
    gb_v.delete(); gb_c.delete();
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    budget = 0;
    while (!(gb_v.size() >= 2 && done_b) && budget < 200) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      budget++;
    end
    chk("b_budget", int'(budget < 200), 1);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b_pulse_count", gb_v.size(), 2);
    mask = 0;
    foreach (gb_v[i]) mask = mask | (1 << gb_v[i]);
    chk("b_value_set", mask, 3);
    if (gb_c.size() > 1) chk_ge("b_gap", gb_c[1] - gb_c[0], PER_B + 1);
    chk("b_all_done", int'(done_b), 1);
    chk("b_draw_cnt", int'(cnt_b), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
